// File: rtl/br_predictor_pkg.sv
// br_predictor_pkg: shared index/tag geometry and 2-bit counter encodings
// used by the predictor and by EX when it builds the resolution fields.
package br_predictor_pkg;

    localparam int BP_INDEX_W = 5;
    localparam int BP_TAG_W   = 12;
    localparam int BP_TAG_LSB = BP_INDEX_W + 2;
    localparam int BP_TAG_MSB = BP_INDEX_W + BP_TAG_W + 1;

    typedef logic [BP_INDEX_W-1:0] BrIndexBus;
    typedef logic [BP_TAG_W-1:0]   BrTagBus;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RST = WNT;

    // A freshly allocated entry starts one step toward its first outcome.
    function automatic ctr_e ctr_alloc(input logic taken);
        return taken ? WT : WNT;
    endfunction

endpackage

// File: rtl/br_predictor_sat_counter2.sv
// sat_counter2: pure next-state function of a 2-bit saturating counter.
module sat_counter2
    import br_predictor_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    output ctr_e nxt
);

    always_comb begin
        nxt = ctr;
        if (taken)
            nxt = (ctr == ST)  ? ST  : ctr_e'(ctr + 2'd1);
        else
            nxt = (ctr == SNT) ? SNT : ctr_e'(ctr - 2'd1);
    end

endmodule

// File: rtl/br_predictor.sv
// br_predictor: tagged bimodal branch predictor trained by EX resolutions.
// Define BP_GSHARE_EN to hash the lookup index with a global history register.
module br_predictor
    import br_predictor_pkg::*;
#(
    parameter int INDEX_W = BP_INDEX_W,
    parameter int TAG_W   = BP_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        if_pc_i,
    output logic               prd_jmp_o,
    output logic [31:0]        prd_pc_o,
    output logic [INDEX_W-1:0] br_index_o,
    input  logic               upd_valid_i,
    input  logic [INDEX_W-1:0] upd_index_i,
    input  logic [TAG_W-1:0]   upd_tag_i,
    input  logic [31:0]        upd_target_i,
    input  logic               upd_taken_i
);

    localparam int ENTRIES = 1 << INDEX_W;

    logic               valid_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q   [ENTRIES];
    logic [31:0]        tgt_q   [ENTRIES];
    ctr_e               ctr_q   [ENTRIES];

    logic [INDEX_W-1:0] pc_idx;
    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic               lk_hit;
    logic               upd_hit;
    ctr_e               ctr_nxt;

    assign pc_idx = if_pc_i[INDEX_W+1:2];
    assign pc_tag = if_pc_i[INDEX_W+TAG_W+1:INDEX_W+2];

`ifdef BP_GSHARE_EN
    logic [INDEX_W-1:0] ghr_q;

    // History only advances on resolved branches, so it never needs repair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ghr_q <= '0;
        else if (upd_valid_i)
            ghr_q <= {ghr_q[INDEX_W-2:0], upd_taken_i};
    end

    assign lk_idx = pc_idx ^ ghr_q;
`else
    assign lk_idx = pc_idx;
`endif

    // Lookup reads registered state only; a same-cycle update is not bypassed.
    assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == pc_tag);
    assign prd_jmp_o  = lk_hit && ctr_q[lk_idx][1];
    assign prd_pc_o   = prd_jmp_o ? tgt_q[lk_idx] : if_pc_i + 32'd4;
    assign br_index_o = lk_idx;

    assign upd_hit = valid_q[upd_index_i] && (tag_q[upd_index_i] == upd_tag_i);

    sat_counter2 u_ctr (
        .ctr   (ctr_q[upd_index_i]),
        .taken (upd_taken_i),
        .nxt   (ctr_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_RST;
            end
        end else if (upd_valid_i) begin
            valid_q[upd_index_i] <= 1'b1;
            tag_q[upd_index_i]   <= upd_tag_i;
            ctr_q[upd_index_i]   <= upd_hit ? ctr_nxt : ctr_alloc(upd_taken_i);
            // A not-taken hit keeps the last known taken target.
            if (upd_taken_i || !upd_hit)
                tgt_q[upd_index_i] <= upd_target_i;
        end
    end

endmodule

// File: tb/tb_br_predictor.sv
// tb_br_predictor: directed table, reset/same-cycle sequences and a
// randomized run against a table-of-records reference model.
module tb_br_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc_i;
    logic        prd_jmp_o;
    logic [31:0] prd_pc_o;
    logic [4:0]  br_index_o;
    logic        upd_valid_i;
    logic [4:0]  upd_index_i;
    logic [11:0] upd_tag_i;
    logic [31:0] upd_target_i;
    logic        upd_taken_i;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    br_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .if_pc_i      (if_pc_i),
        .prd_jmp_o    (prd_jmp_o),
        .prd_pc_o     (prd_pc_o),
        .br_index_o   (br_index_o),
        .upd_valid_i  (upd_valid_i),
        .upd_index_i  (upd_index_i),
        .upd_tag_i    (upd_tag_i),
        .upd_target_i (upd_target_i),
        .upd_taken_i  (upd_taken_i)
    );

    typedef struct {
        logic        upd;
        logic [11:0] tag;
        logic [31:0] tgt;
        logic        taken;
        logic [31:0] pc;
        logic        jmp;
        logic [31:0] npc;
    } vec_t;

    vec_t vecs[$];

    bit          m_v   [32];
    int          m_tag [32];
    logic [31:0] m_tgt [32];
    int          m_ctr [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic upd, input logic [11:0] tag, input logic [31:0] tgt,
                       input logic taken, input logic [31:0] pc, input logic jmp,
                       input logic [31:0] npc);
        vec_t v;
        v.upd = upd; v.tag = tag; v.tgt = tgt; v.taken = taken;
        v.pc = pc; v.jmp = jmp; v.npc = npc;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
    endtask

    task automatic model_update(input int idx, input int tag, input logic [31:0] tgt, input bit taken);
        if (m_v[idx] && m_tag[idx] == tag) begin
            m_ctr[idx] = taken ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                               : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
            if (taken) m_tgt[idx] = tgt;
        end else begin
            m_v[idx] = 1; m_tag[idx] = tag; m_tgt[idx] = tgt;
            m_ctr[idx] = taken ? 2 : 1;
        end
    endtask

    task automatic model_check(input string nm);
        int idx = int'((if_pc_i >> 2) & 32'h1F);
        int tag = int'((if_pc_i >> 7) & 32'hFFF);
        bit jmp = m_v[idx] && m_tag[idx] == tag && m_ctr[idx] >= 2;
        chk({nm, "_jmp"}, {31'd0, prd_jmp_o}, {31'd0, jmp});
        chk({nm, "_pc"}, prd_pc_o, jmp ? m_tgt[idx] : if_pc_i + 32'd4);
        chk({nm, "_idx"}, {27'd0, br_index_o}, 32'(idx));
    endtask

    task automatic idle_inputs();
        upd_valid_i = 0; upd_index_i = 0; upd_tag_i = 0; upd_target_i = 0; upd_taken_i = 0;
    endtask

    initial begin
        logic [31:0] p;
        rst = 1'b0;
        if_pc_i = 32'h100;
        idle_inputs();
        #2;
        chk("rst_jmp", {31'd0, prd_jmp_o}, 32'd0);
        chk("rst_pc", prd_pc_o, 32'h104);
        chk("rst_idx", {27'd0, br_index_o}, 32'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;

        // ctr trajectory at index 0 (tag 2): 10,11,11,11,10,01,00,00,00,01,10,11,10
        add(1, 12'h002, 32'h80,  1, 32'h100, 1, 32'h80);
        add(1, 12'h002, 32'h80,  1, 32'h100, 1, 32'h80);
        add(1, 12'h002, 32'h80,  1, 32'h100, 1, 32'h80);
        add(1, 12'h002, 32'h80,  1, 32'h100, 1, 32'h80);
        add(1, 12'h002, 32'h80,  0, 32'h100, 1, 32'h80);
        add(1, 12'h002, 32'h80,  0, 32'h100, 0, 32'h104);
        add(1, 12'h002, 32'h80,  0, 32'h100, 0, 32'h104);
        add(1, 12'h002, 32'h80,  0, 32'h100, 0, 32'h104);
        add(1, 12'h002, 32'h80,  0, 32'h100, 0, 32'h104);
        add(1, 12'h002, 32'h80,  1, 32'h100, 0, 32'h104);
        add(1, 12'h002, 32'h80,  1, 32'h100, 1, 32'h80);
        add(1, 12'h002, 32'h200, 1, 32'h100, 1, 32'h200);
        add(1, 12'h002, 32'h999, 0, 32'h100, 1, 32'h200);
        // alias 0x180 steals index 0, allocated weakly not-taken
        add(1, 12'h003, 32'h300, 0, 32'h100, 0, 32'h104);
        add(0, 12'h000, 32'h0,   0, 32'h180, 0, 32'h184);
        add(1, 12'h003, 32'h300, 1, 32'h180, 1, 32'h300);
        add(1, 12'h003, 32'h300, 0, 32'h180, 0, 32'h184);
        add(0, 12'h000, 32'h0,   0, 32'hFFFF_FFFC, 0, 32'h0);
        add(0, 12'h000, 32'h0,   0, 32'h100, 0, 32'h104);

        foreach (vecs[i]) begin
            upd_valid_i = vecs[i].upd; upd_index_i = 5'd0; upd_tag_i = vecs[i].tag;
            upd_target_i = vecs[i].tgt; upd_taken_i = vecs[i].taken;
            if_pc_i = vecs[i].pc;
            @(posedge clk); #1;
            idle_inputs();
            #1;
            p = vecs[i].pc;
            chk($sformatf("vec%0d_jmp", i), {31'd0, prd_jmp_o}, {31'd0, vecs[i].jmp});
            chk($sformatf("vec%0d_pc", i), prd_pc_o, vecs[i].npc);
            chk($sformatf("vec%0d_idx", i), {27'd0, br_index_o}, {27'd0, p[6:2]});
        end

        // retrain 0x100, then async reset mid-cycle must clear the prediction at once
        if_pc_i = 32'h100;
        upd_valid_i = 1; upd_index_i = 0; upd_tag_i = 12'h002; upd_target_i = 32'h80; upd_taken_i = 1;
        @(posedge clk); #1;
        idle_inputs(); #1;
        chk("train_jmp", {31'd0, prd_jmp_o}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_jmp", {31'd0, prd_jmp_o}, 32'd0);
        chk("async_rst_pc", prd_pc_o, 32'h104);
        upd_valid_i = 1; upd_index_i = 0; upd_tag_i = 12'h002; upd_target_i = 32'h80; upd_taken_i = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        chk("rst_discard_jmp", {31'd0, prd_jmp_o}, 32'd0);
        chk("rst_discard_pc", prd_pc_o, 32'h104);

        // same-cycle update and lookup: no bypass
        @(posedge clk); #1;
        if_pc_i = 32'h100;
        upd_valid_i = 1; upd_index_i = 0; upd_tag_i = 12'h002; upd_target_i = 32'h80; upd_taken_i = 1;
        #2;
        chk("same_cycle_jmp", {31'd0, prd_jmp_o}, 32'd0);
        @(posedge clk); #1;
        idle_inputs(); #1;
        chk("next_cycle_jmp", {31'd0, prd_jmp_o}, 32'd1);
        chk("next_cycle_pc", prd_pc_o, 32'h80);

        // randomized run against the reference model
        #1 rst = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 1500; n++) begin
            if_pc_i = ($urandom() & 32'hFFF8_0000) | (32'($urandom_range(0, 3)) << 7)
                    | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            upd_valid_i  = 1'($urandom_range(0, 1));
            upd_index_i  = 5'($urandom_range(0, 31));
            upd_tag_i    = 12'($urandom_range(0, 3));
            upd_target_i = $urandom();
            upd_taken_i  = 1'($urandom_range(0, 1));
            #3;
            model_check("rand");
            @(posedge clk);
            if (upd_valid_i)
                model_update(int'(upd_index_i), int'(upd_tag_i), upd_target_i, upd_taken_i);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/br_predictor.md
# br_predictor

Dynamic branch predictor for the 5-stage RISC-V core: the consumer end of the branch-resolution interface the EX stage drives. IF presents its fetch PC and receives a taken/not-taken prediction, a predicted next PC and the table index used. EX later returns the same index with the resolved outcome and target, and this block trains its tables. It sits beside IF/PC and closes the loop with EX.

## Interface
- `INDEX_W`, 5: table index width; entries = 2^INDEX_W, index = pc[INDEX_W+1:2].
- `TAG_W`, 12: tag width; tag = pc[INDEX_W+TAG_W+1:INDEX_W+2], i.e. pc[18:7] at defaults.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_pc_i`  in  32  fetch PC to predict.
- `prd_jmp_o`  out  1  predicted taken.
- `prd_pc_o`  out  32  predicted next PC: stored target if taken, else if_pc_i+4.
- `br_index_o`  out  INDEX_W  table index used; carried down the pipeline to EX.
- `upd_valid_i`  in  1  EX resolved a conditional branch this cycle (EX is_branch).
- `upd_index_i`  in  INDEX_W  index returned by EX (br_index).
- `upd_tag_i`  in  TAG_W  tag of resolved branch PC (br_tag).
- `upd_target_i`  in  32  resolved taken target (jmp_pc).
- `upd_taken_i`  in  1  resolved outcome (branch_taken).

## Operation
- Table per entry: valid (1), tag (TAG_W), target (32), 2-bit saturating counter.
- Lookup, combinational from registered tables: hit = valid && tag == if_pc_i tag. prd_jmp_o = hit && ctr[1]. Otherwise prd_jmp_o=0 and prd_pc_o = if_pc_i+4, wrapping mod 2^32.
- br_index_o is always driven, hit or miss.
- Update, on a rising edge with upd_valid_i=1, at entry upd_index_i:
  - Hit (valid and tag equal): taken moves ctr up, saturating at 11; not-taken moves ctr down, saturating at 00. If taken, target <= upd_target_i. If not taken, target is unchanged.
  - Miss (invalid or tag differs): allocate. valid<=1, tag<=upd_tag_i, target<=upd_target_i, ctr<=taken?10:01.
- upd_valid_i=0: no state change.
- JAL/JALR are never presented for update. Unconditional jumps are not predicted.
- Lookup and update in the same cycle at the same index: lookup sees pre-update contents (no bypass).
- Reset (async, rst=0): all valid=0, ctr=01, tag=0, target=0.
  - During reset and until the first update, prd_jmp_o=0, prd_pc_o=if_pc_i+4, br_index_o = pc index.
  - Reset asserted mid-update discards the update.

## Timing
- Prediction: zero-cycle combinational path, if_pc_i to all three outputs.
- Training: an update sampled at edge N is visible to lookups in the cycle after edge N.
- Back-to-back updates, including to the same index, are accepted every cycle. Each is applied against the result of the previous one.
- No handshake and no backpressure. Updates cannot be dropped.

## Configuration
- `BP_GSHARE_EN` defined:
  - Adds an INDEX_W-bit global history register, reset 0.
  - On each accepted update: ghr <= {ghr[INDEX_W-2:0], upd_taken_i}.
  - Lookup index = pc index XOR ghr. br_index_o outputs this hashed index. Tag is still from the PC.
  - History is non-speculative; it advances only at resolution.
- `BP_GSHARE_EN` undefined: index = pc index, no history register.
- Update always uses upd_index_i as given, so EX behaviour is identical in both builds.

## Structure
- Shared defines package holds: `BrIndexBus` (INDEX_W-1:0), counter encodings (SNT=00, WNT=01, WT=10, ST=11), counter reset value WNT, and the tag bit-range constants. EX uses the same index/tag definitions.
- One sub-module: `sat_counter2`, the pure 2-bit saturating next-state function. It is instantiated once on the update path.
- Tables are flat register arrays, not a memory macro.

## Test plan
- Reset, then lookup pc=0x100 -> prd_jmp_o=0, prd_pc_o=0x104, br_index_o=0.
- Update index 0, tag 0x002, target 0x80, taken. Next cycle, lookup 0x100 -> prd_jmp_o=1, prd_pc_o=0x80.
- From ctr=10: taken x3 -> ST, still predicts taken. Not-taken x1 -> WT, taken. Not-taken x1 -> WNT, lookup 0x100 gives 0x104. Not-taken x3 -> stays SNT.
- Alias: train 0x100 taken, then update 0x180 (same index 0, tag 0x003) not-taken.
  - Lookup 0x100 -> miss, 0x104.
  - Lookup 0x180 -> hit, ctr 01, not taken.
- Same-cycle update and lookup of 0x100 after reset -> prd_jmp_o=0 that cycle, 1 the next.
- Assert rst low mid-stream after training -> prd_jmp_o drops to 0 immediately. With `BP_GSHARE_EN`, ghr=0 and the lookup index equals the pc index.
